// File: rtl/servant_bus_pkg.sv
// Shared definitions for the servant Wishbone bus mux.
// Holds the bus widths, the mux FSM state encoding, the legacy region map and
// a helper that sizes the timeout counter.
package servant_bus_pkg;

    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_e;

    // Legacy region indices (top address bits) of the servant SoC
    localparam int unsigned REGION_MEM   = 0;
    localparam int unsigned REGION_GPIO  = 1;
    localparam int unsigned REGION_TIMER = 2;
    localparam int unsigned REGION_ELUKS = 4;
    localparam int unsigned REGION_BOOT  = 5;

    // Counter width able to hold 0..timeout without wrapping
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/servant_bus_timeout.sv
// Loadable saturating up-counter with an expiry flag for the bus mux.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_load, i_load_val    load the counter (has priority over increment)
//   i_inc                 increment; saturates at TIMEOUT
//   o_expired             counter currently equals TIMEOUT-1 (last allowed wait cycle)
module servant_bus_timeout #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CW      = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_inc,
    output logic          o_expired
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: load wins, increment stops at TIMEOUT so the counter never wraps
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_inc && (cnt_q != CW'(TIMEOUT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expired = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/servant_bus_mux.sv
// Wishbone address-decoding mux between the servant CPU and NUM_SLAVES slaves.
// The top SEL_BITS address bits select a slave region. Slaves flagged in
// EXT_ACK_MASK produce their own ack (bounded by a TIMEOUT-cycle watchdog);
// the others are acked by the mux one cycle after cyc. Accesses to undecoded
// regions and timeouts complete with an error and latch the faulting address.
// Ports:
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_wb_cpu_*                      master request (adr, dat, sel, we, cyc)
//   o_wb_cpu_rdt/ack/err            registered response to the master
//   o_wb_s_adr/dat/sel/we           request broadcast to all slaves
//   o_wb_s_cyc                      per-slave cycle strobe
//   i_wb_s_rdt, i_wb_s_ack          per-slave read data (32 bits each) and ack
//   o_err_valid, o_err_adr          sticky error flag and faulting address
//   i_err_clr                       clears o_err_valid
module servant_bus_mux
    import servant_bus_pkg::*;
#(
    parameter int unsigned          NUM_SLAVES   = 6,
    parameter int unsigned          SEL_BITS     = 3,
    parameter logic [NUM_SLAVES-1:0] EXT_ACK_MASK = '0,
    parameter int unsigned          TIMEOUT      = 255
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [WB_AW-1:0]            i_wb_cpu_adr,
    input  logic [WB_DW-1:0]            i_wb_cpu_dat,
    input  logic [WB_SELW-1:0]          i_wb_cpu_sel,
    input  logic                        i_wb_cpu_we,
    input  logic                        i_wb_cpu_cyc,
    output logic [WB_DW-1:0]            o_wb_cpu_rdt,
    output logic                        o_wb_cpu_ack,
    output logic                        o_wb_cpu_err,
    output logic [WB_AW-1:0]            o_wb_s_adr,
    output logic [WB_DW-1:0]            o_wb_s_dat,
    output logic [WB_SELW-1:0]          o_wb_s_sel,
    output logic                        o_wb_s_we,
    output logic [NUM_SLAVES-1:0]       o_wb_s_cyc,
    input  logic [NUM_SLAVES*WB_DW-1:0] i_wb_s_rdt,
    input  logic [NUM_SLAVES-1:0]       i_wb_s_ack,
    output logic                        o_err_valid,
    output logic [WB_AW-1:0]            o_err_adr,
    input  logic                        i_err_clr
);

    localparam int unsigned CW = cnt_width(TIMEOUT);

    bus_state_e       state_q, state_d;
    logic [WB_DW-1:0] rdt_q, rdt_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             err_valid_q, err_valid_d;
    logic [WB_AW-1:0] err_adr_q, err_adr_d;

    logic [SEL_BITS-1:0] idx_c;
    logic                hit_c;
    logic                sel_ext_c;
    logic                sel_ack_c;
    logic [WB_DW-1:0]    sel_rdt_c;
    logic                tmo_load_c;
    logic                tmo_inc_c;
    logic                tmo_expired_c;
    logic                err_event_c;

    assign idx_c = i_wb_cpu_adr[WB_AW-1 -: SEL_BITS];

    // Broadcast request to every slave
    assign o_wb_s_adr = i_wb_cpu_adr;
    assign o_wb_s_dat = i_wb_cpu_dat;
    assign o_wb_s_sel = i_wb_cpu_sel;
    assign o_wb_s_we  = i_wb_cpu_we;

    // Decode the addressed slave; hit_c stays low for regions >= NUM_SLAVES
    always_comb begin
        hit_c      = 1'b0;
        sel_ext_c  = 1'b0;
        sel_ack_c  = 1'b0;
        sel_rdt_c  = '0;
        o_wb_s_cyc = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_c == SEL_BITS'(k)) begin
                hit_c         = 1'b1;
                sel_ext_c     = EXT_ACK_MASK[k];
                sel_ack_c     = i_wb_s_ack[k];
                sel_rdt_c     = i_wb_s_rdt[k*WB_DW +: WB_DW];
                o_wb_s_cyc[k] = i_wb_cpu_cyc && (state_q != ST_DONE);
            end
        end
    end

    // Next-state and response logic; the counter is held cleared outside WAIT
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdt_d       = rdt_q;
        err_event_c = 1'b0;
        tmo_load_c  = 1'b1;
        tmo_inc_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_wb_cpu_cyc) begin
                    if (!hit_c) begin
                        state_d     = ST_DONE;
                        ack_d       = 1'b1;
                        err_d       = 1'b1;
                        rdt_d       = '0;
                        err_event_c = 1'b1;
                    end else if (!sel_ext_c) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        rdt_d   = sel_rdt_c;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                tmo_load_c = 1'b0;
                if (!i_wb_cpu_cyc) begin
                    state_d    = ST_IDLE;
                    tmo_load_c = 1'b1;
                end else if (sel_ack_c) begin
                    state_d = ST_DONE;
                    ack_d   = 1'b1;
                    rdt_d   = sel_rdt_c;
                end else if (tmo_expired_c) begin
                    state_d     = ST_DONE;
                    ack_d       = 1'b1;
                    err_d       = 1'b1;
                    rdt_d       = '0;
                    err_event_c = 1'b1;
                end else begin
                    tmo_inc_c = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky error capture; a new error beats a simultaneous clear
    always_comb begin
        err_valid_d = err_valid_q && !i_err_clr;
        err_adr_d   = err_adr_q;
        if (err_event_c) begin
            err_valid_d = 1'b1;
            err_adr_d   = i_wb_cpu_adr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            rdt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdt_q       <= rdt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            err_adr_q   <= err_adr_d;
        end
    end

    servant_bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmo_load_c),
        .i_load_val ('0),
        .i_inc      (tmo_inc_c),
        .o_expired  (tmo_expired_c)
    );

    assign o_wb_cpu_rdt = rdt_q;
    assign o_wb_cpu_ack = ack_q;
    assign o_wb_cpu_err = err_q;
    assign o_err_valid  = err_valid_q;
    assign o_err_adr    = err_adr_q;

endmodule
